// File: rtl/dsp_pkg.sv
// Shared constants for the DSP adder slice: carry-in source encodings and
// the legal operand width range.
package dsp_pkg;

   // Carry-in source select encodings (3'b110 / 3'b111 are reserved -> 0)
   localparam logic [2:0] CIN_ZERO   = 3'b000;
   localparam logic [2:0] CIN_ONE    = 3'b001;
   localparam logic [2:0] CIN_CAS    = 3'b010;
   localparam logic [2:0] CIN_FABRIC = 3'b011;
   localparam logic [2:0] CIN_FB     = 3'b100;
   localparam logic [2:0] CIN_FB_N   = 3'b101;

   // Operand width bounds
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 54;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/carry_in_sel.sv
// Combinational six-way carry-in source selector. Reserved encodings force 0.
module carry_in_sel
   import dsp_pkg::*;
(
   input  logic [2:0] sel_i,
   input  logic       ci_i,
   input  logic       cicas_i,
   input  logic       cf_i,
   output logic       cin_o
);

   // Pick the carry-in source; anything not listed is reserved and yields 0
   always_comb begin
      cin_o = 1'b0;
      case (sel_i)
         CIN_ZERO:   cin_o = 1'b0;
         CIN_ONE:    cin_o = 1'b1;
         CIN_CAS:    cin_o = cicas_i;
         CIN_FABRIC: cin_o = ci_i;
         CIN_FB:     cin_o = cf_i;
         CIN_FB_N:   cin_o = ~cf_i;
         default:    cin_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/dsp_carry_adder_pipe.sv
// Two-stage pipelined adder/accumulator slice. Stage 1 registers operands
// and controls; stage 2 adds X + Y + cin and registers SUM/CO/VALID_OUT.
// Bubbles leave SUM, CO and the carry-feedback register untouched so that
// multi-word chains and accumulations survive gaps in the valid stream.
module dsp_carry_adder_pipe
   import dsp_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int ACC_EN = 0
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE,
   input  logic             VALID_IN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   input  logic             CICAS,
   input  logic [2:0]       CARRYMUX_SEL,
   input  logic             ACCUM,
   input  logic             ACC_LOAD,
   output logic [WIDTH-1:0] SUM,
   output logic             CO,
   output logic             CO_CAS,
   output logic             VALID_OUT
);

   // Elaboration-time guard on the operand width
   if (!width_ok(WIDTH)) begin : g_width_check
      $error("dsp_carry_adder_pipe: WIDTH out of range");
   end

   // Stage 1 registers
   logic [WIDTH-1:0] a_q, b_q;
   logic             ci_q, cicas_q, accum_q, acc_load_q, v1_q;
   logic [2:0]       sel_q;

   // Stage 2 registers
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
   logic             vout_q;
   logic             cf_q;

   // Datapath intermediates
   logic             cin;
   logic             accum_eff;
   logic [WIDTH-1:0] y_d;
   logic [WIDTH:0]   sum_full;

   // Stage 1: capture operands and controls on every enabled cycle
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         a_q        <= '0;
         b_q        <= '0;
         ci_q       <= 1'b0;
         cicas_q    <= 1'b0;
         sel_q      <= CIN_ZERO;
         accum_q    <= 1'b0;
         acc_load_q <= 1'b0;
         v1_q       <= 1'b0;
      end else if (CE) begin
         a_q        <= A;
         b_q        <= B;
         ci_q       <= CI;
         cicas_q    <= CICAS;
         sel_q      <= CARRYMUX_SEL;
         accum_q    <= ACCUM;
         acc_load_q <= ACC_LOAD;
         v1_q       <= VALID_IN;
      end
   end

   carry_in_sel u_carry_in_sel (
      .sel_i   (sel_q),
      .ci_i    (ci_q),
      .cicas_i (cicas_q),
      .cf_i    (cf_q),
      .cin_o   (cin)
   );

   // Select Y (B, running SUM, or zero on load) and form the WIDTH+1 bit sum
   always_comb begin
      accum_eff = accum_q & (ACC_EN != 0);
      y_d       = b_q;
      if (accum_eff) begin
         y_d = acc_load_q ? '0 : sum_q;
      end
      sum_full = {1'b0, a_q} + {1'b0, y_d} + {{WIDTH{1'b0}}, cin};
      sum_d    = sum_full[WIDTH-1:0];
      co_d     = sum_full[WIDTH];
   end

   // Stage 2: valid ops update result and feedback carry; bubbles only drop valid
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sum_q  <= '0;
         co_q   <= 1'b0;
         cf_q   <= 1'b0;
         vout_q <= 1'b0;
      end else if (CE) begin
         vout_q <= v1_q;
         if (v1_q) begin
            sum_q <= sum_d;
            co_q  <= co_d;
            cf_q  <= co_d;
         end
      end
   end

   assign SUM       = sum_q;
   assign CO        = co_q;
   assign CO_CAS    = co_q;
   assign VALID_OUT = vout_q;

endmodule

// File: tb/tb_dsp_carry_adder_pipe.sv
// Directed bench for dsp_carry_adder_pipe (WIDTH=18, ACC_EN=1): a vector
// table for carry-source coverage plus hand sequences for latency, chaining,
// accumulation across bubbles / CE-low, and reset mid-pipe.
module tb_dsp_carry_adder_pipe;

   localparam int W = 18;

   logic         CLK = 1'b0;
   logic         RSTN;
   logic         CE;
   logic         VALID_IN;
   logic [W-1:0] A, B;
   logic         CI, CICAS;
   logic [2:0]   CARRYMUX_SEL;
   logic         ACCUM, ACC_LOAD;
   logic [W-1:0] SUM;
   logic         CO, CO_CAS, VALID_OUT;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic         cicas;
      logic [2:0]   sel;
      logic [W-1:0] exp_sum;
      logic         exp_co;
   } vec_t;

   vec_t vecs[$];

   dsp_carry_adder_pipe #(.WIDTH(W), .ACC_EN(1)) dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .CE           (CE),
      .VALID_IN     (VALID_IN),
      .A            (A),
      .B            (B),
      .CI           (CI),
      .CICAS        (CICAS),
      .CARRYMUX_SEL (CARRYMUX_SEL),
      .ACCUM        (ACCUM),
      .ACC_LOAD     (ACC_LOAD),
      .SUM          (SUM),
      .CO           (CO),
      .CO_CAS       (CO_CAS),
      .VALID_OUT    (VALID_OUT)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [W-1:0] s, input logic c, input logic v);
      check({name, ".sum"},    32'(SUM),       32'(s));
      check({name, ".co"},     32'(CO),        32'(c));
      check({name, ".co_cas"}, 32'(CO_CAS),    32'(c));
      check({name, ".valid"},  32'(VALID_OUT), 32'(v));
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic cas, input logic [2:0] sel,
                        input logic acc, input logic ld);
      VALID_IN = v; A = a; B = b; CI = ci; CICAS = cas;
      CARRYMUX_SEL = sel; ACCUM = acc; ACC_LOAD = ld;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic cas, input logic [2:0] sel,
                          input logic [W-1:0] s, input logic c);
      vec_t v;
      v.a = a; v.b = b; v.ci = ci; v.cicas = cas; v.sel = sel;
      v.exp_sum = s; v.exp_co = c;
      vecs.push_back(v);
   endtask

   initial begin
      // Vector table (applied in order: rows after the first CF-setting row depend on CF)
      add_vec(18'h3FFFF, 18'h0,     1'b0, 1'b0, 3'b000, 18'h3FFFF, 1'b0);
      add_vec(18'h3FFFF, 18'h0,     1'b0, 1'b0, 3'b001, 18'h00000, 1'b1);
      add_vec(18'h3FFFF, 18'h0,     1'b0, 1'b1, 3'b010, 18'h00000, 1'b1);
      add_vec(18'h3FFFF, 18'h0,     1'b1, 1'b0, 3'b011, 18'h00000, 1'b1);
      add_vec(18'h3FFFF, 18'h0,     1'b1, 1'b1, 3'b110, 18'h3FFFF, 1'b0);
      add_vec(18'h0,     18'h0,     1'b1, 1'b1, 3'b111, 18'h00000, 1'b0);
      add_vec(18'h3FFFF, 18'h0,     1'b1, 1'b0, 3'b010, 18'h3FFFF, 1'b0);
      add_vec(18'h3FFFF, 18'h0,     1'b0, 1'b1, 3'b011, 18'h3FFFF, 1'b0);
      add_vec(18'h3FFFF, 18'h1,     1'b0, 1'b0, 3'b000, 18'h00000, 1'b1);
      add_vec(18'h5,     18'h5,     1'b0, 1'b0, 3'b101, 18'h0000A, 1'b0);
      add_vec(18'h5,     18'h5,     1'b0, 1'b0, 3'b101, 18'h0000B, 1'b0);
      add_vec(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 3'b001, 18'h3FFFF, 1'b1);
      add_vec(18'h1,     18'h2,     1'b0, 1'b0, 3'b100, 18'h00004, 1'b0);
      add_vec(18'h12345, 18'h0ABCD, 1'b1, 1'b1, 3'b000, 18'h1CF12, 1'b0);

      // Reset block
      RSTN = 1'b0;
      CE   = 1'b1;
      idle();
      tick();
      tick();
      check_out("reset", '0, 1'b0, 1'b0);
      RSTN = 1'b1;
      tick();

      // Latency: valid pulse emerges exactly two enabled cycles later
      drive(1'b1, 18'd5, 18'd7, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      idle();
      check("lat.cycle1_valid", 32'(VALID_OUT), 32'd0);
      tick();
      check_out("lat.cycle2", 18'd12, 1'b0, 1'b1);
      tick();
      check("lat.cycle3_valid", 32'(VALID_OUT), 32'd0);

      // Table-driven carry-source vectors
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].cicas, vecs[i].sel, 1'b0, 1'b0);
         tick();
         idle();
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_co, 1'b1);
      end

      // Multi-word chain at full rate
      drive(1'b1, 18'h3FFFF, 18'h1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      drive(1'b1, 18'h0, 18'h0, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
      tick();
      idle();
      check_out("chain.word0", 18'h0, 1'b1, 1'b1);
      tick();
      check_out("chain.word1", 18'h1, 1'b0, 1'b1);

      // Accumulate: load 10, +3, bubble, CE low 2 cycles, +4
      drive(1'b1, 18'd10, 18'd99, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      tick();
      drive(1'b1, 18'd3, 18'd99, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      tick();
      idle();
      check_out("acc.load", 18'd10, 1'b0, 1'b1);
      tick();
      check_out("acc.add3", 18'd13, 1'b0, 1'b1);
      tick();
      check_out("acc.bubble", 18'd13, 1'b0, 1'b0);
      CE = 1'b0;
      drive(1'b1, 18'd4, 18'd99, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      tick();
      check_out("acc.ce_low1", 18'd13, 1'b0, 1'b0);
      tick();
      check_out("acc.ce_low2", 18'd13, 1'b0, 1'b0);
      CE = 1'b1;
      tick();
      idle();
      check("acc.after_ce_valid", 32'(VALID_OUT), 32'd0);
      tick();
      check_out("acc.add4", 18'd17, 1'b0, 1'b1);
      tick();

      // Reset mid-pipe: first make CF=1, then kill an in-flight op
      drive(1'b1, 18'h3FFFF, 18'h1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      check_out("rst.cf_set", 18'h0, 1'b1, 1'b1);
      drive(1'b1, 18'd9, 18'd9, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      idle();
      RSTN = 1'b0;
      #1;
      check_out("rst.async", '0, 1'b0, 1'b0);
      tick();
      RSTN = 1'b1;
      tick();
      check("rst.no_ghost1", 32'(VALID_OUT), 32'd0);
      tick();
      check("rst.no_ghost2", 32'(VALID_OUT), 32'd0);
      drive(1'b1, 18'd1, 18'd1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      check_out("rst.cf_cleared", 18'd2, 1'b0, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsp_carry_adder_pipe.md
Name: dsp_carry_adder_pipe

Overview:
- Parametrised, pipelined adder/accumulator slice for the DSP datapath. Successor to the combinational carry-in selector.
- Generalises operand width, widens the carry-in select to six sources, and adds input/output registers with a valid pipeline.
- New behaviour: carry feedback for multi-word chaining, and accumulate mode.
- Sits between the multiplier outputs and the cascade chain. CO_CAS feeds the next slice's CICAS.

Parameters:
- WIDTH, 18, operand/result width in bits (2..54).
- ACC_EN, 0, 1 = accumulate path instantiated; 0 = ACCUM input ignored (treated as 0).

Ports:
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all registers hold when low
- VALID_IN  in  1  operands/controls valid this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CI  in  1  fabric carry-in
- CICAS  in  1  cascade carry-in from previous slice
- CARRYMUX_SEL  in  3  carry-in source select
- ACCUM  in  1  1 = add A to current result instead of B (ACC_EN=1 only)
- ACC_LOAD  in  1  with ACCUM=1: load A+carry, discard prior result
- SUM  out  WIDTH  registered result
- CO  out  1  registered carry-out of SUM
- CO_CAS  out  1  copy of CO for cascade routing
- VALID_OUT  out  1  SUM/CO valid

Behaviour:
- Reset (RSTN low, async): all stage-1 and stage-2 registers clear. SUM=0, CO=0, CO_CAS=0, VALID_OUT=0, carry-feedback register=0. Reset mid-operation discards in-flight data; no partial result emerges after release.
- Pipeline, all registers advance only when CE=1:
  - Stage 1 registers A, B, CI, CICAS, CARRYMUX_SEL, ACCUM, ACC_LOAD, VALID_IN.
  - Stage 2 computes and registers SUM, CO, VALID_OUT.
  - Latency: 2 enabled cycles from VALID_IN to VALID_OUT.
- Bubbles: when stage-1 valid=0, stage 2 loads VALID_OUT=0. SUM, CO and the feedback register hold their values (bubbles do not disturb the chain).
- Carry-in mux, evaluated on stage-1 values:
  - 000 → 0
  - 001 → 1
  - 010 → CICAS
  - 011 → CI
  - 100 → CF, the carry-feedback register holding CO of the last valid result (multi-word chaining)
  - 101 → NOT CF (borrow chaining for subtract-by-complement)
  - 110, 111 → reserved, force 0
- Arithmetic: {CO,SUM} = X + Y + cin, computed at WIDTH+1 bits with no saturation.
  - X = A.
  - Y = B when ACCUM=0 (or ACC_EN=0).
  - Y = SUM register when ACCUM=1 and ACC_LOAD=0.
  - Y = 0 when ACCUM=1 and ACC_LOAD=1.
  - Wrap-around: result is modulo 2^WIDTH; overflow is reported only via CO.
- CF update: loads the new CO on every valid stage-2 update.
  - Back-to-back valid ops with sel=100 chain correctly at full rate (the feedback path is one cycle).
  - First chained op after reset uses CF=0.
- Accumulate with a bubble in between: uses the held SUM, so accumulation is bubble-tolerant.
- CE low with VALID_IN high: the input is not captured. Upstream must hold it until CE is high.
- CO_CAS equals CO at all times. Combinational delay from CICAS to CO_CAS is through registers only (no combinational cascade path).

Decomposition:
- Shared package (dsp_pkg):
  - CARRYMUX_SEL encodings as named localparams: CIN_ZERO, CIN_ONE, CIN_CAS, CIN_FABRIC, CIN_FB, CIN_FB_N.
  - WIDTH bounds check constants.
- One natural sub-module: carry_in_sel.
  - Combinational 6-way source mux: 3-bit sel, CI, CICAS, CF → cin.
  - Instantiated once in stage 2.

Test Plan:
- Reset/latency, WIDTH=18: RSTN low, then high. A=5, B=7, sel=000, VALID_IN pulse → VALID_OUT high exactly 2 cycles later with SUM=12, CO=0. All outputs were 0 during reset.
- Carry sources: A=0x3FFFF, B=0, sweep sel 000/001/010(CICAS=1)/011(CI=1)/110 → SUM/CO = 3FFFF/0, 00000/1, 00000/1, 00000/1, 3FFFF/0.
- Multi-word chain: word0 A=0x3FFFF, B=1, sel=000; then back-to-back word1 A=0, B=0, sel=100 → word0 SUM=0, CO=1; word1 SUM=1, CO=0.
- Accumulate, ACC_EN=1: ACC_LOAD op A=10, then ACCUM ops A=3, A=4 with a bubble and CE low for 2 cycles in between → SUM sequence 10, 13, 17. VALID_OUT low during the bubble. SUM held.
- Reset mid-pipe: issue valid op, assert RSTN low after 1 cycle → VALID_OUT never asserts for that op. CF=0 on next sel=100 op (A=1, B=1 → SUM=2).
- Reserved select: sel=111, CI=1, CICAS=1, A=B=0 → SUM=0, CO=0.
